hash_feat_fetch: RTL and testbench
==================================

HASH_FEAT_FETCH -- requirements
Module: hash_feat_fetch

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32: width of each incoming hash index.
REQ-002 SHALL have parameter ADDR_WIDTH, default 19: feature-table SRAM address width.
REQ-003 SHALL have parameter FEAT_WIDTH, default 16: width of one feature element.
REQ-004 SHALL have parameter N_FEAT, default 2: feature elements per table entry; entry width EW = N_FEAT*FEAT_WIDTH.
REQ-005 SHALL have parameter RD_LAT, default 1, legal range 1..4: SRAM read latency in cycles.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-009 SHALL have port hash_idx[0:7], input, DATA_SIZE each: hashed corner indices, corner order 0..7.
REQ-010 SHALL have port base_addr, input, ADDR_WIDTH: level base address in the shared table.
REQ-011 SHALL have ports mem_rd_en (output, 1) and mem_rd_addr (output, ADDR_WIDTH): SRAM read request.
REQ-012 SHALL have port mem_rd_data, input, EW: SRAM read data.
REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-014 SHALL have port feat[0:7], output, EW each: fetched entries, feat[k] belonging to hash_idx[k].

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN and OUT.
REQ-016 SHALL drive in_ready=1 only in IDLE; a request is accepted on a cycle with in_valid && in_ready.
REQ-017 SHALL, on accept, register all eight hash_idx and base_addr and go to ISSUE.
REQ-018 SHALL ignore in_valid and input data outside IDLE; registered values stay unchanged.
REQ-019 SHALL, in ISSUE, assert mem_rd_en for exactly 8 consecutive cycles, corner k on the k-th cycle.
REQ-020 SHALL form mem_rd_addr = (base_addr + hash_idx[k][ADDR_WIDTH-1:0]) mod 2^ADDR_WIDTH, with carry out discarded.
REQ-021 SHALL drive mem_rd_addr to 0 whenever mem_rd_en=0.
REQ-022 SHALL treat mem_rd_data as valid in the cycle exactly RD_LAT cycles after the matching mem_rd_en cycle.
REQ-023 SHALL route returned data to the correct slot using a RD_LAT-deep valid/corner-tag shift register, without relying on a state counter.
REQ-024 SHALL go from ISSUE to DRAIN after the 8th issue; SHALL stay in DRAIN until the 8th return is captured, then go to OUT.
REQ-025 SHALL, counting the accept cycle as cycle 0, issue in cycles 1..8, capture the last return in cycle 8+RD_LAT, and raise out_valid from cycle 9+RD_LAT (cycle 10 when RD_LAT=1).
REQ-026 SHALL hold out_valid and feat[0:7] stable in OUT until out_valid && out_ready.
REQ-027 SHALL return to IDLE on the output handshake, with in_ready=1 in the next cycle; there is no same-cycle back-to-back accept.
REQ-028 SHALL ignore out_ready when out_valid=0.
REQ-029 SHALL keep feat[0:7] holding the last delivered result outside OUT; the values are refreshed slot by slot during capture.
REQ-030 SHALL handle duplicate indices normally, issuing all 8 reads with no merging.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, force: state IDLE, in_ready=1 after reset, out_valid=0, mem_rd_en=0, mem_rd_addr=0, all feat=0, tag pipe cleared.
REQ-032 SHALL, on reset mid-ISSUE/DRAIN, discard in-flight reads; data arriving after reset deassertion is not captured.

Verification
REQ-033 Basic fetch: RD_LAT=1, base_addr=0x100, hash_idx={0..7}, SRAM model returning addr -> mem_rd_addr 0x100..0x107 in cycles 1..8, out_valid at cycle 10, feat[k]=0x100+k.
REQ-034 Address wrap: base_addr=0x7FFFF, hash_idx[0]=1, hash_idx[1]=0x80005 -> addresses 0x00000 and 0x00004.
REQ-035 Latency sweep: RD_LAT=3 with the same stimulus as REQ-033 -> out_valid at cycle 12, feat unchanged vs RD_LAT=1.
REQ-036 Backpressure: out_ready=0 for 20 cycles after out_valid -> feat stable and in_ready=0 throughout; new in_valid is ignored; handshake then in_ready=1 next cycle.
REQ-037 Reset mid-operation: rst asserted in cycle 5 of ISSUE -> mem_rd_en=0 next cycle, out_valid never rises, feat all 0; the next request completes correctly.
REQ-038 Back-to-back: two requests with in_valid held high, out_ready=1 -> second accept one cycle after the first output handshake; both results correct.

Source files
------------

// File: rtl/hash_feat_fetch.sv
// ---------------------------------------------------------------------------
// hash_feat_fetch
//
// Fetches the eight feature-table entries addressed by one set of hashed
// corner indices. A request carries eight hash indices and a level base
// address. Each corner address is base_addr + hash_idx[k], truncated to
// ADDR_WIDTH bits. The block issues the eight SRAM reads back to back,
// collects the returned entries into feat[0:7] and presents them as one
// result.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   in_valid/in_ready request handshake (in_ready only while idle)
//   hash_idx[0:7]     hashed corner indices, DATA_SIZE bits each
//   base_addr         level base address in the shared table
//   mem_rd_en/addr    SRAM read request (addr forced to 0 when not reading)
//   mem_rd_data       SRAM read data, valid RD_LAT cycles after mem_rd_en
//   out_valid/ready   result handshake
//   feat[0:7]         fetched entries, feat[k] belongs to hash_idx[k]
//   dbg_state         current FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 OUT)
//
// Handshake rule, for both the request and the result side: a transfer
// happens on a rising edge where valid && ready are both 1. The sender holds
// valid and its data stable until that edge. The receiver may drive ready
// without waiting for valid. The block never raises in_ready in the same
// cycle as an output transfer, so one request is in flight at a time.
//
// Timing, counting the accept cycle as 0: reads issue in cycles 1..8. The
// last entry returns in cycle 8+RD_LAT. out_valid rises in cycle 9+RD_LAT.
// RD_LAT must be in the range 1..4.
// ---------------------------------------------------------------------------
module hash_feat_fetch #(
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_WIDTH = 19,
    parameter int FEAT_WIDTH = 16,
    parameter int N_FEAT     = 2,
    parameter int RD_LAT     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_SIZE-1:0]           hash_idx [0:7],
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    output logic                           mem_rd_en,
    output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
    input  logic [N_FEAT*FEAT_WIDTH-1:0]   mem_rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_FEAT*FEAT_WIDTH-1:0]   feat [0:7],
    output logic [1:0]                     dbg_state
);

    localparam int EW = N_FEAT * FEAT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_WIDTH-1:0]   r_base;
    logic [ADDR_WIDTH-1:0]   r_idx [0:7];
    logic [2:0]              r_issue_k;
    logic [EW-1:0]           r_feat [0:7];

    // Tag pipe: one stage per cycle of read latency. Each stage records
    // whether a read was issued and which corner it was for. The oldest
    // stage therefore lines up exactly with the cycle its data arrives.
    logic                    r_tag_vld [RD_LAT];
    logic [2:0]              r_tag     [RD_LAT];

    logic                    w_accept;
    logic                    w_cap_vld;
    logic [2:0]              w_cap_tag;
    logic                    w_last_cap;

    // Only the low ADDR_WIDTH bits of each index are part of the address.
    // The upper bits are folded here so the unused inputs stay visible.
    logic [7:0]              w_unused_idx_hi;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_unused_idx_hi[k] = ^hash_idx[k];
        end
    end

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_cap_vld  = r_tag_vld[RD_LAT-1];
    assign w_cap_tag  = r_tag[RD_LAT-1];
    // Returns come back in issue order, so corner 7 is always the last one.
    assign w_last_cap = w_cap_vld && (w_cap_tag == 3'd7);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)             w_next = S_ISSUE;
            S_ISSUE: if (r_issue_k == 3'd7)    w_next = S_DRAIN;
            S_DRAIN: if (w_last_cap)           w_next = S_OUT;
            S_OUT:   if (out_ready)            w_next = S_IDLE;
            default:                           w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        dbg_state   = r_state;
        case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_ISSUE: begin
                mem_rd_en   = 1'b1;
                // Carry out of the top address bit is dropped on purpose.
                mem_rd_addr = r_base + r_idx[r_issue_k];
            end
            S_OUT:   out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request registers, issue counter, tag pipe, result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base    <= '0;
            r_issue_k <= '0;
            for (int k = 0; k < 8; k++) begin
                r_idx[k]  <= '0;
                r_feat[k] <= '0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_vld[i] <= 1'b0;
                r_tag[i]     <= '0;
            end
        end else begin
            if (w_accept) begin
                r_base    <= base_addr;
                r_issue_k <= '0;
                for (int k = 0; k < 8; k++) begin
                    r_idx[k] <= hash_idx[k][ADDR_WIDTH-1:0];
                end
            end else if (r_state == S_ISSUE) begin
                r_issue_k <= r_issue_k + 3'd1;
            end

            r_tag_vld[0] <= mem_rd_en;
            r_tag[0]     <= r_issue_k;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag[i]     <= r_tag[i-1];
            end

            if (w_cap_vld) begin
                r_feat[w_cap_tag] <= mem_rd_data;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            feat[k] = r_feat[k];
        end
    end

endmodule

// File: tb/tb_hash_feat_fetch.sv
// ---------------------------------------------------------------------------
// Testbench for hash_feat_fetch. Two instances share one request stream:
// one with RD_LAT=1 and one with RD_LAT=3. Each instance has its own SRAM
// model that returns the read address as data.
// ---------------------------------------------------------------------------
module tb_hash_feat_fetch;

    localparam int AW = 19;
    localparam int EW = 32;
    localparam int PW = 8 * EW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            rst;
    logic            in_valid;
    logic            out_ready;
    logic [31:0]     hash_idx [0:7];
    logic [AW-1:0]   base_addr;

    // instance with RD_LAT=1
    logic            in_ready1, mem_rd_en1, out_valid1;
    logic [AW-1:0]   mem_rd_addr1;
    logic [EW-1:0]   mem_rd_data1;
    logic [EW-1:0]   feat1 [0:7];
    logic [1:0]      dbg1;
    // instance with RD_LAT=3
    logic            in_ready3, mem_rd_en3, out_valid3;
    logic [AW-1:0]   mem_rd_addr3;
    logic [EW-1:0]   mem_rd_data3;
    logic [EW-1:0]   feat3 [0:7];
    logic [1:0]      dbg3;

    hash_feat_fetch #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .hash_idx(hash_idx), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en1), .mem_rd_addr(mem_rd_addr1), .mem_rd_data(mem_rd_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .feat(feat1), .dbg_state(dbg1)
    );

    hash_feat_fetch #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .hash_idx(hash_idx), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en3), .mem_rd_addr(mem_rd_addr3), .mem_rd_data(mem_rd_data3),
        .out_valid(out_valid3), .out_ready(out_ready), .feat(feat3), .dbg_state(dbg3)
    );

    // ---------------- SRAM models: data = read address, junk otherwise ----
    logic            m1_v = 1'b0;
    logic [AW-1:0]   m1_a = '0;
    always @(posedge clk) begin
        m1_v <= mem_rd_en1;
        m1_a <= mem_rd_addr1;
    end
    assign mem_rd_data1 = m1_v ? {13'd0, m1_a} : 32'hDEADBEEF;

    logic [2:0]      m3_v = 3'b000;
    logic [AW-1:0]   m3_a0 = '0, m3_a1 = '0, m3_a2 = '0;
    always @(posedge clk) begin
        m3_v  <= {m3_v[1:0], mem_rd_en3};
        m3_a0 <= mem_rd_addr3;
        m3_a1 <= m3_a0;
        m3_a2 <= m3_a1;
    end
    assign mem_rd_data3 = m3_v[2] ? {13'd0, m3_a2} : 32'hDEADBEEF;

    logic [PW-1:0] fp1, fp3;
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            fp1[PW-1-k*EW -: EW] = feat1[k];
            fp3[PW-1-k*EW -: EW] = feat3[k];
        end
    end

    // ---------------- scoreboard ----------------
    logic [PW-1:0] exp_q0[$], exp_q1[$];
    logic [AW-1:0] addr_q0[$], addr_q1[$];
    int n_cmp  = 0;
    int n_fail = 0;

    int acc_cyc [2];
    int hs_cyc  [2];
    int n_iss   [2];
    logic acc_seen [2];
    logic prev_ov  [2];
    logic b2b_mode = 1'b0;

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, got, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s @cyc %0d", name, cyc);
    endtask

    function automatic logic [PW-1:0] pack_addr(input logic [AW-1:0] ea [0:7]);
        logic [PW-1:0] r;
        for (int k = 0; k < 8; k++) r[PW-1-k*EW -: EW] = {13'd0, ea[k]};
        return r;
    endfunction

    // Monitor for one instance, evaluated on the falling edge.
    task automatic mon(input int d, input logic ir, input logic en, input logic [AW-1:0] a,
                       input logic ov, input logic [PW-1:0] fp, input int lat);
        logic [AW-1:0] ea;
        logic [PW-1:0] ef;
        logic          have;
        if (rst) begin
            prev_ov[d] = 1'b0;
            return;
        end
        if (in_valid && ir) begin
            acc_seen[d] = 1'b1;
            if (b2b_mode && hs_cyc[d] >= 0) check("b2b_gap", PW'(cyc - hs_cyc[d]), PW'(1));
            acc_cyc[d] = cyc;
            n_iss[d]   = 0;
        end
        if (en) begin
            have = 1'b0;
            ea   = '0;
            if (d == 0 && addr_q0.size() > 0) begin ea = addr_q0.pop_front(); have = 1'b1; end
            if (d == 1 && addr_q1.size() > 0) begin ea = addr_q1.pop_front(); have = 1'b1; end
            if (!have) fail_msg("rd_addr_unexpected");
            else       check("rd_addr", PW'(a), PW'(ea));
            check("issue_cycle", PW'(cyc - acc_cyc[d]), PW'(n_iss[d] + 1));
            n_iss[d]++;
        end else begin
            check("rd_addr_idle", PW'(a), PW'(0));
        end
        if (ov && !prev_ov[d]) check("out_latency", PW'(cyc - acc_cyc[d]), PW'(9 + lat));
        if (ov && out_ready) begin
            have = 1'b0;
            ef   = '0;
            if (d == 0 && exp_q0.size() > 0) begin ef = exp_q0.pop_front(); have = 1'b1; end
            if (d == 1 && exp_q1.size() > 0) begin ef = exp_q1.pop_front(); have = 1'b1; end
            if (!have) fail_msg("feat_unexpected");
            else       check("feat", fp, ef);
            hs_cyc[d] = cyc;
        end
        prev_ov[d] = ov;
    endtask

    always @(negedge clk) begin
        mon(0, in_ready1, mem_rd_en1, mem_rd_addr1, out_valid1, fp1, 1);
        mon(1, in_ready3, mem_rd_en3, mem_rd_addr3, out_valid3, fp3, 3);
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic [AW-1:0] b, input logic [31:0] idx [0:7]);
        base_addr = b;
        for (int k = 0; k < 8; k++) hash_idx[k] = idx[k];
    endtask

    task automatic push_exp(input logic [AW-1:0] ea [0:7]);
        for (int k = 0; k < 8; k++) begin
            addr_q0.push_back(ea[k]);
            addr_q1.push_back(ea[k]);
        end
        exp_q0.push_back(pack_addr(ea));
        exp_q1.push_back(pack_addr(ea));
    endtask

    // Small address model for requests without a hand table.
    task automatic push_model(input logic [AW-1:0] b, input logic [31:0] idx [0:7]);
        logic [AW-1:0] ea [0:7];
        for (int k = 0; k < 8; k++) ea[k] = b + idx[k][AW-1:0];
        push_exp(ea);
    endtask

    task automatic wait_accept();
        logic done;
        acc_seen[0] = 1'b0;
        acc_seen[1] = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk); #1;
            done = acc_seen[0] && acc_seen[1];
        end
        if (!done) fail_msg("accept_timeout");
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            done = (exp_q0.size() == 0) && (exp_q1.size() == 0) &&
                   (addr_q0.size() == 0) && (addr_q1.size() == 0);
        end
        if (!done) fail_msg("drain_timeout");
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [31:0]   idx_a [0:7];
    logic [31:0]   idx_b [0:7];
    logic [AW-1:0] ea    [0:7];
    logic          seen_ov;
    logic [PW-1:0] exp_c;

    initial begin
        for (int d = 0; d < 2; d++) begin
            acc_cyc[d] = 0; hs_cyc[d] = -1; n_iss[d] = 0;
            acc_seen[d] = 1'b0; prev_ov[d] = 1'b0;
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; base_addr = '0;
        for (int k = 0; k < 8; k++) hash_idx[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check("rst_in_ready",  PW'({in_ready1, in_ready3}),   PW'(2'b11));
        check("rst_out_valid", PW'({out_valid1, out_valid3}), PW'(2'b00));
        check("rst_rd_en",     PW'({mem_rd_en1, mem_rd_en3}), PW'(2'b00));
        check("rst_rd_addr",   PW'({mem_rd_addr1, mem_rd_addr3}), PW'(0));
        check("rst_feat1",     fp1, '0);
        check("rst_feat3",     fp3, '0);
        check("rst_state",     PW'({dbg1, dbg3}), PW'(4'b0000));
        rst = 1'b0;

        // basic fetch: addresses 0x100..0x107, feat[k] = 0x100+k
        idx_a = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        ea    = '{19'h100, 19'h101, 19'h102, 19'h103, 19'h104, 19'h105, 19'h106, 19'h107};
        set_req(19'h100, idx_a);
        push_exp(ea);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        wait_drain();

        // address wrap, duplicate indices, upper index bits ignored
        idx_a = '{32'h1, 32'h80005, 32'h2, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h100000, 32'h12345};
        ea    = '{19'h00000, 19'h00004, 19'h00001, 19'h00002,
                  19'h7FFFE, 19'h7FFFE, 19'h7FFFF, 19'h12344};
        set_req(19'h7FFFF, idx_a);
        push_exp(ea);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        wait_drain();

        // back-to-back with in_valid held; inputs change while busy
        idx_a = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        idx_b = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80};
        set_req(19'h1000, idx_a);
        push_model(19'h1000, idx_a);
        in_valid = 1'b1;
        wait_accept();
        b2b_mode = 1'b1;
        set_req(19'h2000, idx_b);
        push_model(19'h2000, idx_b);
        wait_accept();
        b2b_mode = 1'b0;
        in_valid = 1'b0;
        wait_drain();

        // backpressure: 20 cycles of out_ready=0 with a competing request
        out_ready = 1'b0;
        idx_a = '{32'hA0, 32'hA1, 32'hB2, 32'hB3, 32'hC4, 32'hC5, 32'hD6, 32'hD7};
        for (int k = 0; k < 8; k++) ea[k] = 19'h30000 + idx_a[k][AW-1:0];
        exp_c = pack_addr(ea);
        set_req(19'h30000, idx_a);
        push_exp(ea);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        seen_ov = 1'b0;
        for (int i = 0; i < 40 && !seen_ov; i++) begin
            @(posedge clk); #1;
            seen_ov = out_valid1;
        end
        if (!seen_ov) fail_msg("bp_out_valid_timeout");
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) hash_idx[k] = $urandom_range(32'h7FFF, 0);
        base_addr = 19'h55555;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_feat_stable", fp1, exp_c);
            check("bp_hold", PW'({out_valid1, in_ready1}), PW'(2'b10));
        end
        check("bp_feat3", fp3, exp_c);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", PW'({in_ready1, in_ready3}), PW'(2'b11));
        wait_drain();

        // reset in cycle 5 of the request (fifth issue cycle)
        idx_a = '{32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2};
        set_req(19'h200, idx_a);
        push_model(19'h200, idx_a);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q0.delete(); exp_q1.delete(); addr_q0.delete(); addr_q1.delete();
        @(negedge clk);
        check("rstmid_rd_en", PW'({mem_rd_en1, mem_rd_en3}), PW'(2'b00));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rstmid_no_out", PW'({out_valid1, out_valid3}), PW'(2'b00));
            check("rstmid_feat1", fp1, '0);
            check("rstmid_feat3", fp3, '0);
        end
        check("rstmid_in_ready", PW'({in_ready1, in_ready3}), PW'(2'b11));
        @(posedge clk); #1;

        // request after reset completes normally
        idx_a = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
        set_req(19'h40000, idx_a);
        push_model(19'h40000, idx_a);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        wait_drain();

        repeat (3) @(posedge clk);
        check("end_exp_q_empty",  PW'(exp_q0.size() + exp_q1.size()),   PW'(0));
        check("end_addr_q_empty", PW'(addr_q0.size() + addr_q1.size()), PW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
